control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Multi-cycle control unit that sits directly upstream of the datapath. It decodes the IR value the datapath returns and sequences every enable, bus-select, memory-read, PC-increment and ALU OP signal the datapath consumes. It runs the fetch / decode / execute steps for the team ISA and handshakes with memory through mem_ready.

Parameters:
- RESET_PC_HOLD, 1: cycles held in RESET after clr deasserts before the first fetch.
- OP_W, 5: width of the ALU operation code and of the instruction opcode field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- ir  in  32  IR register contents. opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- con_ff  in  1  branch condition flip-flop from the datapath.
- mem_ready  in  1  memory has completed the current read or write.
- stop  in  1  pause request, honoured only at an instruction boundary.
- reg_in  out  16  one-hot R0in..R15in.
- reg_out  out  16  one-hot R0out..R15out.
- enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI, enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_con  out  1 each  register load enables.
- select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C  out  1 each  bus source selects.
- inc_pc  out  1  PC self-increment.
- read  out  2  MDR input mux select: 00 = bus, 01 = memory data.
- mem_read, mem_write  out  1 each  memory strobes.
- op  out  5  ALU operation.
- run  out  1  high while executing.

Behaviour:
- **Reset (clr=1, asynchronous):**
  - state=RESET, every output 0, run=0.
  - After clr falls: RESET_PC_HOLD cycles, then go to F0 with run=1.
- **Output timing:** outputs are combinational decodes of the registered state plus ir (Moore style). At most one select_* or reg_out bit is high in any cycle.
- **Fetch (3 cycles minimum):**
  - F0: select_PC, enable_MAR, inc_pc.
  - F1: mem_read, read=01, enable_MDR. Stay in F1 while mem_ready=0.
  - F2: select_MDR, enable_IR.
- **Execute states:** E3..E7. Register fields decode to one-hot reg_in/reg_out. Per opcode class:
  - R-type (add, sub, and, or, shr, shl, ror, rol):
    - E3: reg_out[rb], enable_Y.
    - E4: reg_out[rc], op=opcode, enable_ZLO, enable_ZHI.
    - E5: select_ZLO, reg_in[ra].
    - Total 6 cycles at zero wait.
  - I-type (addi, andi, ori, ldi):
    - E3: reg_out[rb], enable_Y.
    - E4: select_C, op (ADD for ldi, else opcode), enable_ZLO.
    - E5: select_ZLO, reg_in[ra].
  - ld:
    - E3–E4 as ldi.
    - E5: select_ZLO, enable_MAR.
    - E6: mem_read, read=01, enable_MDR; wait on mem_ready.
    - E7: select_MDR, reg_in[ra].
  - st:
    - E3–E5 as ld.
    - E6: reg_out[ra], read=00, enable_MDR.
    - E7: mem_write; wait on mem_ready.
  - mul/div:
    - E3: reg_out[ra], enable_Y.
    - E4: reg_out[rb], op, enable_ZHI, enable_ZLO.
    - E5: select_ZLO, enable_LO.
    - E6: select_ZHI, enable_HI.
  - br:
    - E3: reg_out[ra], enable_con.
    - E4: select_PC, enable_Y.
    - E5: select_C, op=ADD, enable_ZLO.
    - E6: when con_ff=1, select_ZLO and enable_PC; when con_ff=0, no load.
  - mfhi / mflo: E3: select_HI or select_LO, reg_in[ra].
  - nop, and any undefined opcode: return to F0 immediately after F2.
  - halt: go to HALT with run=0; held until clr.
- **Instruction boundary:**
  - Last execute state goes to F0.
  - If stop=1 at the boundary, go to IDLE (run=0). Leave IDLE for F0 when stop=0.
- **Memory handshake:**
  - Strobes and enables stay asserted for the whole wait.
  - mem_ready sampled outside a wait state is ignored.
  - mem_ready=1 on the first cycle of a wait state gives zero wait.
- **clr mid-instruction:** immediate return to RESET; no partial register write after the clr edge.

Decomposition:
- Package cpu_pkg:
  - opcode constants (ADD=00011, SUB=00100, AND=00101, OR=00110, SHR..ROL=00111..01010, ADDI=01011, ANDI=01100, ORI=01101, MUL=01111, DIV=10000, LD=00000, LDI=00001, ST=00010, BR=10010, MFHI=10111, MFLO=11000, NOP=11010, HALT=11011);
  - state enum;
  - ALU_ADD constant.
- Sub-module reg_decoder_4_16: 4-bit field + enable -> 16-bit one-hot. Three instances (ra in, ra/rb/rc out muxed).

Test Plan:
- clr pulse, then ir=0x18918000 (add R1,R2,R3), mem_ready tied 1 -> F0..E5 in 6 cycles; E3 reg_out=0x0004, E4 reg_out=0x0008 with op=00011, E5 reg_in=0x0002.
- ld with mem_ready low 3 cycles in E6 -> E6 held 4 cycles with mem_read=1 and read=01 throughout; E7 select_MDR with reg_in[ra].
- br with con_ff=0, then con_ff=1 -> E6 enable_PC=0, then enable_PC=1 with select_ZLO=1.
- stop=1 raised mid-execute of add -> add completes; state IDLE, run=0. stop=0 -> F0 next cycle.
- clr asserted in E4 of mul -> all outputs 0 asynchronously; no enable_LO/enable_HI pulse afterwards.
- opcode 11011 (halt) -> run=0 after F2; outputs stay 0 for 20 cycles despite mem_ready toggling.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and control-word layout for
// the multi-cycle control unit.
package cpu_pkg;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_ROR  = 5'b01001;
  localparam logic [4:0] OPC_ROL  = 5'b01010;
  localparam logic [4:0] OPC_ADDI = 5'b01011;
  localparam logic [4:0] OPC_ANDI = 5'b01100;
  localparam logic [4:0] OPC_ORI  = 5'b01101;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_BR   = 5'b10010;
  localparam logic [4:0] OPC_MFHI = 5'b10111;
  localparam logic [4:0] OPC_MFLO = 5'b11000;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD  = OPC_ADD;

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7, S_IDLE, S_HALT
  } state_e;

  // Instructions grouped by the shape of their execute sequence.
  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LD, CL_ST, CL_MD, CL_BR, CL_MF, CL_NOP, CL_HALT
  } opclass_e;

  // Internal control word; register-field decode enables ride along.
  typedef struct packed {
    logic       en_pc, en_ir, en_hi, en_lo, en_zhi, en_zlo, en_mar, en_mdr, en_y, en_con;
    logic       sel_pc, sel_hi, sel_lo, sel_zhi, sel_zlo, sel_mdr, sel_c;
    logic       inc_pc;
    logic [1:0] read;
    logic       mem_read, mem_write;
    logic [4:0] op;
    logic       run;
    logic       in_en;    // reg_in[ra]
    logic       out_ra;   // reg_out[ra]
    logic       out_rbc;  // reg_out[rb] or reg_out[rc]
    logic       use_rc;   // picks rc over rb for out_rbc
  } ctrl_t;

  // Undefined opcodes fall into the NOP class.
  function automatic opclass_e classify(input logic [4:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL:   return CL_R;
      OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_LDI: return CL_I;
      OPC_LD:                               return CL_LD;
      OPC_ST:                               return CL_ST;
      OPC_MUL, OPC_DIV:                     return CL_MD;
      OPC_BR:                               return CL_BR;
      OPC_MFHI, OPC_MFLO:                   return CL_MF;
      OPC_HALT:                             return CL_HALT;
      default:                              return CL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. master = control unit, slave = datapath.
interface control_sequencer_if #(parameter int OP_W = 5);
  logic [31:0]     ir;
  logic            con_ff, mem_ready, stop;
  logic [15:0]     reg_in, reg_out;
  logic            enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI;
  logic            enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_con;
  logic            select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C;
  logic            inc_pc;
  logic [1:0]      read;
  logic            mem_read, mem_write;
  logic [OP_W-1:0] op;
  logic            run;

  modport master (
    input  ir, con_ff, mem_ready, stop,
    output reg_in, reg_out,
           enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI,
           enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_con,
           select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C,
           inc_pc, read, mem_read, mem_write, op, run
  );

  modport slave (
    output ir, con_ff, mem_ready, stop,
    input  reg_in, reg_out,
           enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI,
           enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_con,
           select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C,
           inc_pc, read, mem_read, mem_write, op, run
  );
endinterface

// File: rtl/reg_decoder_4_16.sv
// 4-bit register field to 16-bit one-hot, all zero when disabled.
module reg_decoder_4_16 (
  input  logic [3:0]  field_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);
  // Single hot bit at field_i when enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[field_i] = 1'b1;
  end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer. State is registered; every
// datapath control is a decode of the state and the current IR (con_ff only
// gates the branch PC load).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1,
  parameter int OP_W          = 5
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);

  state_e     state_q;
  logic [7:0] hold_q;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc, rbc;
  opclass_e   cls;
  state_e     bnd;
  ctrl_t      c;
  logic [15:0] out_a, out_b;

  assign opc = bus.ir[31:27];
  assign ra  = bus.ir[26:23];
  assign rb  = bus.ir[22:19];
  assign rc  = bus.ir[18:15];
  assign cls = classify(opc);
  // Where an instruction ends: pause if asked, otherwise fetch the next.
  assign bnd = bus.stop ? S_IDLE : S_F0;

  // State sequencing; clr drops straight back to RESET from anywhere.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
      hold_q  <= '0;
    end else begin
      case (state_q)
        S_RESET: if (int'(hold_q) + 1 >= RESET_PC_HOLD) state_q <= S_F0;
                 else hold_q <= hold_q + 8'd1;
        S_F0:    state_q <= S_F1;
        S_F1:    if (bus.mem_ready) state_q <= S_F2;
        S_F2:    case (cls)
                   CL_NOP:  state_q <= bnd;
                   CL_HALT: state_q <= S_HALT;
                   default: state_q <= S_E3;
                 endcase
        S_E3:    state_q <= (cls == CL_MF) ? bnd : S_E4;
        S_E4:    state_q <= S_E5;
        S_E5:    state_q <= (cls == CL_R || cls == CL_I) ? bnd : S_E6;
        S_E6:    case (cls)
                   CL_LD:   if (bus.mem_ready) state_q <= S_E7;
                   CL_ST:   state_q <= S_E7;
                   default: state_q <= bnd;
                 endcase
        S_E7:    if (cls != CL_ST || bus.mem_ready) state_q <= bnd;
        S_IDLE:  if (!bus.stop) state_q <= S_F0;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

  // Control word decode from state and instruction class.
  always_comb begin
    c     = '0;
    c.run = !(state_q == S_RESET || state_q == S_IDLE || state_q == S_HALT);
    case (state_q)
      S_F0: begin c.sel_pc = 1'b1; c.en_mar = 1'b1; c.inc_pc = 1'b1; end
      S_F1: begin c.mem_read = 1'b1; c.read = 2'b01; c.en_mdr = 1'b1; end
      S_F2: begin c.sel_mdr = 1'b1; c.en_ir = 1'b1; end
      S_E3: case (cls)
              CL_R, CL_I, CL_LD, CL_ST: begin c.out_rbc = 1'b1; c.en_y = 1'b1; end
              CL_MD: begin c.out_ra = 1'b1; c.en_y = 1'b1; end
              CL_BR: begin c.out_ra = 1'b1; c.en_con = 1'b1; end
              CL_MF: begin
                c.sel_hi = (opc == OPC_MFHI);
                c.sel_lo = (opc != OPC_MFHI);
                c.in_en  = 1'b1;
              end
              default: ;
            endcase
      S_E4: case (cls)
              CL_R, CL_MD: begin
                c.out_rbc = 1'b1;
                c.use_rc  = (cls == CL_R);
                c.op      = opc;
                c.en_zlo  = 1'b1;
                c.en_zhi  = 1'b1;
                c.out_ra  = 1'b0;
              end
              CL_I, CL_LD, CL_ST: begin
                c.sel_c  = 1'b1;
                c.op     = (cls == CL_I && opc != OPC_LDI) ? opc : ALU_ADD;
                c.en_zlo = 1'b1;
              end
              CL_BR: begin c.sel_pc = 1'b1; c.en_y = 1'b1; end
              default: ;
            endcase
      S_E5: case (cls)
              CL_R, CL_I:   begin c.sel_zlo = 1'b1; c.in_en = 1'b1; end
              CL_LD, CL_ST: begin c.sel_zlo = 1'b1; c.en_mar = 1'b1; end
              CL_MD:        begin c.sel_zlo = 1'b1; c.en_lo = 1'b1; end
              CL_BR:        begin c.sel_c = 1'b1; c.op = ALU_ADD; c.en_zlo = 1'b1; end
              default: ;
            endcase
      S_E6: case (cls)
              CL_LD: begin c.mem_read = 1'b1; c.read = 2'b01; c.en_mdr = 1'b1; end
              CL_ST: begin c.out_ra = 1'b1; c.read = 2'b00; c.en_mdr = 1'b1; end
              CL_MD: begin c.sel_zhi = 1'b1; c.en_hi = 1'b1; end
              CL_BR: if (bus.con_ff) begin c.sel_zlo = 1'b1; c.en_pc = 1'b1; end
              default: ;
            endcase
      S_E7: case (cls)
              CL_LD: begin c.sel_mdr = 1'b1; c.in_en = 1'b1; end
              CL_ST: c.mem_write = 1'b1;
              default: ;
            endcase
      default: ;
    endcase
  end

  assign rbc = c.use_rc ? rc : rb;

  reg_decoder_4_16 u_in_ra   (.field_i(ra),  .en_i(c.in_en),   .onehot_o(bus.reg_in));
  reg_decoder_4_16 u_out_ra  (.field_i(ra),  .en_i(c.out_ra),  .onehot_o(out_a));
  reg_decoder_4_16 u_out_rbc (.field_i(rbc), .en_i(c.out_rbc), .onehot_o(out_b));

  assign bus.reg_out    = out_a | out_b;
  assign bus.enable_PC  = c.en_pc;
  assign bus.enable_IR  = c.en_ir;
  assign bus.enable_HI  = c.en_hi;
  assign bus.enable_LO  = c.en_lo;
  assign bus.enable_ZHI = c.en_zhi;
  assign bus.enable_ZLO = c.en_zlo;
  assign bus.enable_MAR = c.en_mar;
  assign bus.enable_MDR = c.en_mdr;
  assign bus.enable_Y   = c.en_y;
  assign bus.enable_con = c.en_con;
  assign bus.select_PC  = c.sel_pc;
  assign bus.select_HI  = c.sel_hi;
  assign bus.select_LO  = c.sel_lo;
  assign bus.select_ZHI = c.sel_zhi;
  assign bus.select_ZLO = c.sel_zlo;
  assign bus.select_MDR = c.sel_mdr;
  assign bus.select_C   = c.sel_c;
  assign bus.inc_pc     = c.inc_pc;
  assign bus.read       = c.read;
  assign bus.mem_read   = c.mem_read;
  assign bus.mem_write  = c.mem_write;
  assign bus.op         = OP_W'(c.op);
  assign bus.run        = c.run;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int HOLD = 1;

  localparam logic [4:0] O_LD = 5'd0,  O_LDI = 5'd1,  O_ST = 5'd2,  O_ADD = 5'd3;
  localparam logic [4:0] O_SUB = 5'd4, O_AND = 5'd5,  O_OR = 5'd6,  O_SHR = 5'd7;
  localparam logic [4:0] O_SHL = 5'd8, O_ROR = 5'd9,  O_ROL = 5'd10, O_ADDI = 5'd11;
  localparam logic [4:0] O_ANDI = 5'd12, O_ORI = 5'd13, O_MUL = 5'd15, O_DIV = 5'd16;
  localparam logic [4:0] O_BR = 5'd18, O_MFHI = 5'd23, O_MFLO = 5'd24, O_NOP = 5'd26;
  localparam logic [4:0] O_HALT = 5'd27;

  localparam int EN_PC = 0, EN_IR = 1, EN_HI = 2, EN_LO = 3, EN_ZHI = 4;
  localparam int EN_ZLO = 5, EN_MAR = 6, EN_MDR = 7, EN_Y = 8, EN_CON = 9;
  localparam int SL_PC = 0, SL_HI = 1, SL_LO = 2, SL_ZHI = 3, SL_ZLO = 4, SL_MDR = 5, SL_C = 6;

  typedef struct packed {
    logic [15:0] rin, rout;
    logic [9:0]  en;
    logic [6:0]  sel;
    logic        inc;
    logic [1:0]  rd;
    logic        mr, mw;
    logic [4:0]  op;
    logic        run;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] ir;
    logic        mr, stp, cf, clr;
  } cyc_t;

  logic clk = 1'b0;
  logic clr;
  control_sequencer_if #(.OP_W(5)) bus ();

  control_sequencer #(.RESET_PC_HOLD(HOLD), .OP_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  cyc_t  prog[$];
  string ptag[$];
  vec_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic [31:0] cur_ir;
  logic        cur_cf, cur_clr, quiet;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rmr();
    return quiet ? 1'b1 : rbit();
  endfunction

  function automatic logic rstp();
    return quiet ? 1'b0 : rbit();
  endfunction

  function automatic vec_t base(input logic r);
    vec_t v = '0;
    v.run = r;
    return v;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] f);
    return 16'h0001 << f;
  endfunction

  task automatic add(input vec_t v, input logic mr, input logic stp, input string tag);
    cyc_t t;
    t.v = v; t.ir = cur_ir; t.mr = mr; t.stp = stp; t.cf = cur_cf; t.clr = cur_clr;
    prog.push_back(t);
    ptag.push_back(tag);
  endtask

  task automatic add_wait(input vec_t v, input int n, input string tag);
    for (int i = 0; i < n; i++) add(v, 1'b0, rstp(), tag);
    add(v, 1'b1, rstp(), tag);
  endtask

  task automatic gen_fetch(input int wf);
    vec_t v;
    v = base(1); v.sel[SL_PC] = 1; v.en[EN_MAR] = 1; v.inc = 1; add(v, rmr(), rstp(), "F0");
    v = base(1); v.mr = 1; v.rd = 2'b01; v.en[EN_MDR] = 1;        add_wait(v, wf, "F1");
    v = base(1); v.sel[SL_MDR] = 1; v.en[EN_IR] = 1;              add(v, rmr(), rstp(), "F2");
  endtask

  task automatic gen_exec(input int wm);
    vec_t v;
    logic [4:0] oc;
    logic [3:0] ra, rb, rc;
    oc = cur_ir[31:27]; ra = cur_ir[26:23]; rb = cur_ir[22:19]; rc = cur_ir[18:15];
    if (oc inside {O_ADD, O_SUB, O_AND, O_OR, O_SHR, O_SHL, O_ROR, O_ROL}) begin
      v = base(1); v.rout = oh(rb); v.en[EN_Y] = 1; add(v, rmr(), rstp(), "R.E3");
      v = base(1); v.rout = oh(rc); v.op = oc; v.en[EN_ZLO] = 1; v.en[EN_ZHI] = 1;
      add(v, rmr(), rstp(), "R.E4");
      v = base(1); v.sel[SL_ZLO] = 1; v.rin = oh(ra); add(v, rmr(), rstp(), "R.E5");
    end else if (oc inside {O_ADDI, O_ANDI, O_ORI, O_LDI, O_LD, O_ST}) begin
      v = base(1); v.rout = oh(rb); v.en[EN_Y] = 1; add(v, rmr(), rstp(), "I.E3");
      v = base(1); v.sel[SL_C] = 1; v.en[EN_ZLO] = 1;
      v.op = (oc inside {O_ADDI, O_ANDI, O_ORI}) ? oc : O_ADD;
      add(v, rmr(), rstp(), "I.E4");
      if (oc == O_LD || oc == O_ST) begin
        v = base(1); v.sel[SL_ZLO] = 1; v.en[EN_MAR] = 1; add(v, rmr(), rstp(), "M.E5");
        if (oc == O_LD) begin
          v = base(1); v.mr = 1; v.rd = 2'b01; v.en[EN_MDR] = 1; add_wait(v, wm, "LD.E6");
          v = base(1); v.sel[SL_MDR] = 1; v.rin = oh(ra); add(v, rmr(), rstp(), "LD.E7");
        end else begin
          v = base(1); v.rout = oh(ra); v.en[EN_MDR] = 1; add(v, rmr(), rstp(), "ST.E6");
          v = base(1); v.mw = 1; add_wait(v, wm, "ST.E7");
        end
      end else begin
        v = base(1); v.sel[SL_ZLO] = 1; v.rin = oh(ra); add(v, rmr(), rstp(), "I.E5");
      end
    end else if (oc == O_MUL || oc == O_DIV) begin
      v = base(1); v.rout = oh(ra); v.en[EN_Y] = 1; add(v, rmr(), rstp(), "MD.E3");
      v = base(1); v.rout = oh(rb); v.op = oc; v.en[EN_ZHI] = 1; v.en[EN_ZLO] = 1;
      add(v, rmr(), rstp(), "MD.E4");
      v = base(1); v.sel[SL_ZLO] = 1; v.en[EN_LO] = 1; add(v, rmr(), rstp(), "MD.E5");
      v = base(1); v.sel[SL_ZHI] = 1; v.en[EN_HI] = 1; add(v, rmr(), rstp(), "MD.E6");
    end else if (oc == O_BR) begin
      v = base(1); v.rout = oh(ra); v.en[EN_CON] = 1; add(v, rmr(), rstp(), "BR.E3");
      v = base(1); v.sel[SL_PC] = 1; v.en[EN_Y] = 1; add(v, rmr(), rstp(), "BR.E4");
      v = base(1); v.sel[SL_C] = 1; v.op = O_ADD; v.en[EN_ZLO] = 1; add(v, rmr(), rstp(), "BR.E5");
      v = base(1);
      if (cur_cf) begin v.sel[SL_ZLO] = 1; v.en[EN_PC] = 1; end
      add(v, rmr(), rstp(), "BR.E6");
    end else if (oc == O_MFHI || oc == O_MFLO) begin
      v = base(1); v.rin = oh(ra);
      if (oc == O_MFHI) v.sel[SL_HI] = 1; else v.sel[SL_LO] = 1;
      add(v, rmr(), rstp(), "MF.E3");
    end
  endtask

  task automatic gen_instr(input logic [31:0] instr, input int wf, input int wm,
                           input logic cf, input logic stp_end, input int idle_n);
    cyc_t t;
    cur_ir = instr; cur_cf = cf;
    gen_fetch(wf);
    if (instr[31:27] == O_HALT) begin
      for (int i = 0; i < 20; i++) add(base(0), 1'(i & 1), rstp(), "HALT");
      return;
    end
    gen_exec(wm);
    t = prog.pop_back(); t.stp = stp_end; prog.push_back(t);
    if (stp_end)
      for (int i = 0; i < idle_n; i++) add(base(0), rmr(), (i < idle_n - 1), "IDLE");
  endtask

  always @(negedge clk) begin : mon
    vec_t  a, e;
    string t;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.rin  = bus.reg_in;
      a.rout = bus.reg_out;
      a.en   = {bus.enable_con, bus.enable_Y, bus.enable_MDR, bus.enable_MAR, bus.enable_ZLO,
                bus.enable_ZHI, bus.enable_LO, bus.enable_HI, bus.enable_IR, bus.enable_PC};
      a.sel  = {bus.select_C, bus.select_MDR, bus.select_ZLO, bus.select_ZHI,
                bus.select_LO, bus.select_HI, bus.select_PC};
      a.inc  = bus.inc_pc;
      a.rd   = bus.read;
      a.mr   = bus.mem_read;
      a.mw   = bus.mem_write;
      a.op   = bus.op;
      a.run  = bus.run;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", t, cyc, a, e);
      end
      if (t == "rst" || t == "clrmid" || t == "HALT") begin
        checks++;
        if (a !== vec_t'('0)) begin
          errors++;
          $display("FAIL reset-state %s cyc=%0d got=%h", t, cyc, a);
        end
      end
      if (t == "F1" || t == "LD.E6") begin
        checks++;
        if (a.mr !== 1'b1 || a.rd !== 2'b01 || a.en[EN_MDR] !== 1'b1) begin
          errors++;
          $display("FAIL wait-hold %s cyc=%0d got=%h", t, cyc, a);
        end
      end
      if (t == "ST.E7") begin
        checks++;
        if (a.mw !== 1'b1) begin
          errors++;
          $display("FAIL write-hold %s cyc=%0d got=%h", t, cyc, a);
        end
      end
      checks++;
      if ($countones({a.sel, a.rout}) > 1) begin
        errors++;
        $display("FAIL bus-source %s cyc=%0d sel=%b rout=%h", t, cyc, a.sel, a.rout);
      end
    end
  end

  logic [4:0] pool [25] = '{O_LD, O_LDI, O_ST, O_ADD, O_SUB, O_AND, O_OR, O_SHR, O_SHL,
                            O_ROR, O_ROL, O_ADDI, O_ANDI, O_ORI, O_MUL, O_DIV, O_BR,
                            O_MFHI, O_MFLO, O_NOP, 5'd14, 5'd17, 5'd20, 5'd31, O_BR};

  initial begin
    vec_t v;
    logic [31:0] r;
    clr = 1'b1; bus.ir = '0; bus.con_ff = 1'b0; bus.mem_ready = 1'b0; bus.stop = 1'b0;
    quiet = 1'b1; cur_clr = 1'b1; cur_ir = '0; cur_cf = 1'b0;

    repeat (2) add(base(0), 1'b0, 1'b0, "rst");
    cur_clr = 1'b0;
    repeat (HOLD) add(base(0), 1'b1, 1'b0, "rsthold");

    gen_instr(32'h18918000, 0, 0, 1'b0, 1'b0, 0);
    quiet = 1'b0;
    gen_instr({O_LD, 4'd5, 4'd6, 19'd0}, 1, 3, 1'b0, 1'b0, 0);
    gen_instr({O_BR, 4'd7, 23'd0}, 0, 0, 1'b0, 1'b0, 0);
    gen_instr({O_BR, 4'd7, 23'd0}, 0, 0, 1'b1, 1'b0, 0);
    gen_instr(32'h18918000, 0, 0, 1'b0, 1'b1, 3);
    gen_instr({O_ST, 4'd9, 4'd4, 19'd0}, 2, 2, 1'b0, 1'b0, 0);
    gen_instr({O_NOP, 27'd0}, 0, 0, 1'b0, 1'b1, 2);

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      gen_instr({pool[$urandom_range(0, 24)], r[26:0]}, $urandom_range(0, 2),
                $urandom_range(0, 3), rbit(), ($urandom_range(0, 5) == 0),
                $urandom_range(1, 3));
    end

    cur_ir = {O_MUL, 4'd3, 4'd12, 19'd0}; cur_cf = 1'b0;
    gen_fetch(1);
    v = base(1); v.rout = oh(4'd3); v.en[EN_Y] = 1; add(v, rmr(), 1'b0, "MD.E3");
    cur_clr = 1'b1;
    repeat (3) add(base(0), 1'b1, 1'b0, "clrmid");
    cur_clr = 1'b0;
    repeat (HOLD) add(base(0), 1'b1, 1'b0, "clrhold");

    gen_instr({O_ADDI, 4'd2, 4'd8, 19'd0}, 0, 0, 1'b0, 1'b0, 0);
    gen_instr({O_HALT, 27'd0}, 0, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < prog.size(); i++) begin
      @(posedge clk); #1;
      clr           = prog[i].clr;
      bus.ir        = prog[i].ir;
      bus.mem_ready = prog[i].mr;
      bus.stop      = prog[i].stp;
      bus.con_ff    = prog[i].cf;
      exp_q.push_back(prog[i].v);
      tag_q.push_back(ptag[i]);
    end
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
